draw_sequencer: RTL and testbench
=================================

// Module: draw_sequencer
// PURPOSE
//  Downstream consumer of the sprite drawers (player, laser, enemy). Once per video
//  frame it starts each drawer in turn and waits for its done. It streams that
//  drawer's (x, y, colour index) pixels into the VGA framebuffer write port,
//  mapping the index through a fixed RGB palette. Owns all framebuffer write access.
// PARAMETERS
//  N_DRAWERS    3        number of drawer slots; slot 0 drawn first
//  SCREEN_W     640      pixels with x >= SCREEN_W are dropped
//  SCREEN_H     480      pixels with y >= SCREEN_H are dropped
//  MAX_CYCLES   4096     per-drawer streaming cycle budget before forced abort
// PORTS
//  clock        in   1          system clock
//  reset_n      in   1          asynchronous, active-low reset
//  frame_tick   in   1          1-cycle pulse at vertical blank start
//  drw_x        in   N*10       packed drawer x outputs, slot i at [i*10 +: 10]
//  drw_y        in   N*9        packed drawer y outputs, slot i at [i*9 +: 9]
//  drw_color    in   N*4        packed drawer colour indices
//  drw_done     in   N          drawer done flags
//  drw_init     out  1          global init pulse to all drawers (their global_reset)
//  drw_start    out  N          one-hot 1-cycle start pulse (drives a drawer's reset)
//  fb_x         out  10         framebuffer write x
//  fb_y         out  9          framebuffer write y
//  fb_rgb       out  24         framebuffer write data {R,G,B}
//  fb_we        out  1          framebuffer write enable
//  busy         out  1          high from launch of slot 0 until frame_done
//  frame_done   out  1          1-cycle pulse after last slot finishes
//  overrun      out  1          sticky: frame_tick arrived while busy
//  timeout      out  1          sticky: a drawer exceeded MAX_CYCLES
// BEHAVIOUR
//  - Reset (async assert, sync release): state S_INIT; all outputs 0; idx=0; flags cleared.
//  - S_INIT (1 cycle): drw_init=1 -> S_WAITINIT. Stay MAX_CYCLES cycles or until
//    &drw_done, then -> S_IDLE. Drawers paint the initial sprites here with fb_we=0.
//  - S_IDLE: on frame_tick or pending -> S_LAUNCH, idx=0, clear pending.
//  - S_LAUNCH (1 cycle): drw_start = 1<<idx (Moore decode) -> S_ARM.
//  - S_ARM (1 cycle): drawer is in its start state; drw_done[idx] may be stale.
//    Ignore all inputs; fb_we=0 -> S_STREAM, clear cycle counter.
//  - S_STREAM: each cycle, if !drw_done[idx], register slot idx's x/y/colour into
//    fb_* next cycle. fb_we=1 only if x<SCREEN_W and y<SCREEN_H. This drops
//    underflow-wrapped coordinates.
//  - S_STREAM exit on drw_done[idx]=1 or counter==MAX_CYCLES-1 (latter sets timeout).
//    If idx==N_DRAWERS-1 -> S_IDLE with frame_done=1; else idx++ -> S_LAUNCH.
//  - Latency: exactly 1 cycle from sampled drawer output to fb_* / fb_we.
//    fb_we deasserts the cycle after the last written pixel.
//  - frame_tick while busy: set pending and overrun. The next frame starts
//    immediately on return to S_IDLE. Multiple ticks collapse into one pending.
//  - frame_tick in the same cycle as frame_done: treated as pending, no overrun.
//  - Palette: color 0 bg=000000, 1 player=00FF00, 2 laser=FF0000, 3 enemy=FFFFFF.
//    Indices 4..15 map to FF00FF (visible error colour).
//  - busy = state in {LAUNCH, ARM, STREAM}. Drawers not selected receive no start.
//  - Mid-operation reset_n assertion aborts immediately; fb_we=0 asynchronously.
// STRUCTURE
//  - Shared package gfx_pkg: colour index constants (BG/PLAYER/LASER/ENEMY), the
//    palette function idx->rgb24, SCREEN_W/H defaults, and the state enum typedef.
//  - One sub-module: draw_mux (combinational slot select of x/y/colour/done by idx).
//  - FSM, cycle counter, idx counter, and output registers live in draw_sequencer.
// TESTING
//  - Reset, then release: drw_init high exactly 1 cycle. fb_we stays 0 through S_WAITINIT.
//  - Model drawers emit 4 pixels each, then done. Send frame_tick: drw_start pulses
//    001, 010, 100 in order, fb_we high 12 cycles total, then frame_done exactly once.
//  - Slot 1 stimulus:
//    - pixel x=700, y=10: fb_we stays 0 that cycle.
//    - pixel x=639, y=479: written with fb_rgb=FF0000 when colour=2.
//  - frame_tick during slot 0 stream: overrun=1. A second frame begins the cycle after frame_done.
//  - Slot 2 done never rises: timeout=1 after 4096 stream cycles, frame_done still pulses.
//  - Stale done=1 held through S_ARM: not treated as completion. Drawer with zero
//    pixels gives 0 writes and 3-cycle slot time.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics definitions: colour indices, the fixed RGB palette,
// default screen geometry and the draw sequencer state encoding.
package gfx_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  localparam logic [3:0] COLOR_BG     = 4'd0;
  localparam logic [3:0] COLOR_PLAYER = 4'd1;
  localparam logic [3:0] COLOR_LASER  = 4'd2;
  localparam logic [3:0] COLOR_ENEMY  = 4'd3;

  localparam logic [23:0] RGB_BG     = 24'h000000;
  localparam logic [23:0] RGB_PLAYER = 24'h00FF00;
  localparam logic [23:0] RGB_LASER  = 24'hFF0000;
  localparam logic [23:0] RGB_ENEMY  = 24'hFFFFFF;
  // Unassigned indices show up as magenta so bad colour data is obvious on screen.
  localparam logic [23:0] RGB_ERROR  = 24'hFF00FF;

  typedef enum logic [2:0] {
    S_INIT,
    S_WAITINIT,
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_STREAM
  } seq_state_e;

  function automatic logic [23:0] palette(input logic [3:0] idx);
    case (idx)
      COLOR_BG:     palette = RGB_BG;
      COLOR_PLAYER: palette = RGB_PLAYER;
      COLOR_LASER:  palette = RGB_LASER;
      COLOR_ENEMY:  palette = RGB_ENEMY;
      default:      palette = RGB_ERROR;
    endcase
  endfunction

endpackage

// File: rtl/draw_mux.sv
// Combinational slot selector: picks one drawer's x/y/colour/done from the
// packed drawer buses using the sequencer's current slot index.
module draw_mux #(
  parameter int N_DRAWERS = 3,
  parameter int IDX_W     = 2
) (
  input  logic [IDX_W-1:0]       idx,
  input  logic [N_DRAWERS*10-1:0] drw_x,
  input  logic [N_DRAWERS*9-1:0]  drw_y,
  input  logic [N_DRAWERS*4-1:0]  drw_color,
  input  logic [N_DRAWERS-1:0]    drw_done,
  output logic [9:0]              sel_x,
  output logic [8:0]              sel_y,
  output logic [3:0]              sel_color,
  output logic                    sel_done
);

  // Select the slot addressed by idx; out-of-range indices read as idle zeros.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    sel_done  = 1'b0;
    for (int i = 0; i < N_DRAWERS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_x     = drw_x[i*10 +: 10];
        sel_y     = drw_y[i*9 +: 9];
        sel_color = drw_color[i*4 +: 4];
        sel_done  = drw_done[i];
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Frame draw sequencer: once per frame starts each sprite drawer in turn,
// streams its pixels through the palette into the framebuffer write port,
// and owns all framebuffer write access.
module draw_sequencer
  import gfx_pkg::*;
#(
  parameter int N_DRAWERS  = 3,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int MAX_CYCLES = 4096
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    frame_tick,
  input  logic [N_DRAWERS*10-1:0] drw_x,
  input  logic [N_DRAWERS*9-1:0]  drw_y,
  input  logic [N_DRAWERS*4-1:0]  drw_color,
  input  logic [N_DRAWERS-1:0]    drw_done,
  output logic                    drw_init,
  output logic [N_DRAWERS-1:0]    drw_start,
  output logic [9:0]              fb_x,
  output logic [8:0]              fb_y,
  output logic [23:0]             fb_rgb,
  output logic                    fb_we,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int IDX_W = (N_DRAWERS > 1) ? $clog2(N_DRAWERS) : 1;
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DRAWERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [10:0]      X_LIM    = 11'(SCREEN_W);
  localparam logic [9:0]       Y_LIM    = 10'(SCREEN_H);

  seq_state_e       state, state_n;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic             drw_init_q;
  logic             frame_done_q;
  logic             overrun_q;
  logic             timeout_q;

  // Control strobes decoded by the FSM for the datapath registers.
  logic cnt_clr, cnt_inc;
  logic idx_clr, idx_inc;
  logic capture, set_timeout, frame_end, pend_clr, init_pulse;

  logic [9:0] sel_x;
  logic [8:0] sel_y;
  logic [3:0] sel_color;
  logic       sel_done;
  logic       in_range;
  logic       cnt_last;

  draw_mux #(
    .N_DRAWERS (N_DRAWERS),
    .IDX_W     (IDX_W)
  ) u_draw_mux (
    .idx       (idx),
    .drw_x     (drw_x),
    .drw_y     (drw_y),
    .drw_color (drw_color),
    .drw_done  (drw_done),
    .sel_x     (sel_x),
    .sel_y     (sel_y),
    .sel_color (sel_color),
    .sel_done  (sel_done)
  );

  // Coordinates that wrapped below zero land far above the screen and are dropped here.
  assign in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
  assign cnt_last = (cnt == CNT_LAST);

  assign busy       = (state == S_LAUNCH) || (state == S_ARM) || (state == S_STREAM);
  assign drw_start  = (state == S_LAUNCH) ? (N_DRAWERS'(1) << idx) : '0;
  assign drw_init   = drw_init_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) state <= S_INIT;
    else          state <= state_n;
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    state_n     = state;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    capture     = 1'b0;
    set_timeout = 1'b0;
    frame_end   = 1'b0;
    pend_clr    = 1'b0;
    init_pulse  = 1'b0;
    case (state)
      S_INIT: begin
        init_pulse = 1'b1;
        cnt_clr    = 1'b1;
        state_n    = S_WAITINIT;
      end
      S_WAITINIT: begin
        // Drawers are being reset while drw_init is high, so their done is not yet meaningful.
        if ((&drw_done && !drw_init_q) || cnt_last) state_n = S_IDLE;
        else                                        cnt_inc = 1'b1;
      end
      S_IDLE: begin
        if (frame_tick || pending) begin
          idx_clr  = 1'b1;
          pend_clr = 1'b1;
          state_n  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_n = S_ARM;
      end
      S_ARM: begin
        // The drawer is only now leaving its start state; its done may still be stale.
        cnt_clr = 1'b1;
        state_n = S_STREAM;
      end
      S_STREAM: begin
        capture = !sel_done;
        if (sel_done || cnt_last) begin
          set_timeout = !sel_done;
          if (idx == IDX_LAST) begin
            frame_end = 1'b1;
            state_n   = S_IDLE;
          end else begin
            idx_inc = 1'b1;
            state_n = S_LAUNCH;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  // Slot index and per-phase cycle counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
      cnt <= '0;
    end else begin
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + IDX_W'(1);
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame bookkeeping: pending tick, sticky error flags and single-cycle pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      frame_done_q <= 1'b0;
      drw_init_q   <= 1'b0;
    end else begin
      // A tick outside idle is remembered; repeated ticks collapse into one request.
      pending      <= (pending && !pend_clr) || (frame_tick && (state != S_IDLE));
      if (frame_tick && busy) overrun_q <= 1'b1;
      if (set_timeout)        timeout_q <= 1'b1;
      frame_done_q <= frame_end;
      drw_init_q   <= init_pulse;
    end
  end

  // Framebuffer write port: one-cycle registered copy of the selected drawer pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fb_we  <= 1'b0;
      fb_x   <= '0;
      fb_y   <= '0;
      fb_rgb <= '0;
    end else begin
      fb_we <= capture && in_range;
      if (capture) begin
        fb_x   <= sel_x;
        fb_y   <= sel_y;
        fb_rgb <= palette(sel_color);
      end
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: behavioural drawers replay pixel
// lists, a monitor records writes/starts/frame_done with cycle stamps, and a
// frame-level model predicts the exact write stream and timing.
module tb_draw_sequencer;

  localparam int N        = 3;
  localparam int MAXC     = 4096;
  localparam int MAXPIX   = 64;
  localparam int IDLE_PTR = 1 << 20;

  logic            clock;
  logic            reset_n;
  logic            frame_tick;
  logic [N*10-1:0] drw_x;
  logic [N*9-1:0]  drw_y;
  logic [N*4-1:0]  drw_color;
  logic [N-1:0]    drw_done;
  logic            drw_init;
  logic [N-1:0]    drw_start;
  logic [9:0]      fb_x;
  logic [8:0]      fb_y;
  logic [23:0]     fb_rgb;
  logic            fb_we;
  logic            busy;
  logic            frame_done;
  logic            overrun;
  logic            timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  draw_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .drw_x      (drw_x),
    .drw_y      (drw_y),
    .drw_color  (drw_color),
    .drw_done   (drw_done),
    .drw_init   (drw_init),
    .drw_start  (drw_start),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .fb_rgb     (fb_rgb),
    .fb_we      (fb_we),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Drawer pixel lists; a hanging drawer repeats pixel 0 and never finishes.
  logic [9:0] px_x [N][MAXPIX];
  logic [8:0] px_y [N][MAXPIX];
  logic [3:0] px_c [N][MAXPIX];
  int         n_pix [N];
  bit         hang  [N];
  int         ptr   [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      n_pix[i] = 0;
      hang[i]  = 1'b0;
    end
  end

  // Drawer progress: start -> one stale cycle -> one pixel per cycle -> done.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) ptr[i] <= IDLE_PTR;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (drw_init)                                    ptr[i] <= IDLE_PTR;
        else if (drw_start[i])                           ptr[i] <= -1;
        else if (ptr[i] == -1)                           ptr[i] <= 0;
        else if (!hang[i] && ptr[i] < n_pix[i])          ptr[i] <= ptr[i] + 1;
      end
    end
  end

  // Drawer outputs; the stale cycle shows done=1 plus an on-screen junk pixel.
  always_comb begin
    drw_x     = '0;
    drw_y     = '0;
    drw_color = '0;
    drw_done  = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i] == -1) begin
        drw_done[i]         = 1'b1;
        drw_x[i*10 +: 10]   = 10'd5;
        drw_y[i*9 +: 9]     = 9'd5;
        drw_color[i*4 +: 4] = 4'd1;
      end else if (ptr[i] >= IDLE_PTR) begin
        drw_done[i] = 1'b1;
      end else if (hang[i]) begin
        drw_x[i*10 +: 10]   = px_x[i][0];
        drw_y[i*9 +: 9]     = px_y[i][0];
        drw_color[i*4 +: 4] = px_c[i][0];
      end else if (ptr[i] < n_pix[i]) begin
        drw_x[i*10 +: 10]   = px_x[i][ptr[i]];
        drw_y[i*9 +: 9]     = px_y[i][ptr[i]];
        drw_color[i*4 +: 4] = px_c[i][ptr[i]];
      end else begin
        drw_done[i] = 1'b1;
      end
    end
  end

  // Monitor.
  typedef struct { int cyc; logic [9:0] x; logic [8:0] y; logic [23:0] rgb; } wr_t;
  typedef struct { int cyc; logic [N-1:0] start; } st_t;
  wr_t wr_q [$];
  st_t st_q [$];
  int  done_q [$];
  int  init_cycles = 0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (fb_we)          wr_q.push_back('{cyc, fb_x, fb_y, fb_rgb});
      if (drw_start != 0) st_q.push_back('{cyc, drw_start});
      if (frame_done)     done_q.push_back(cyc);
      if (drw_init)       init_cycles++;
    end
  end

  function automatic logic [23:0] ref_rgb(input int c);
    case (c)
      0:       ref_rgb = 24'h000000;
      1:       ref_rgb = 24'h00FF00;
      2:       ref_rgb = 24'hFF0000;
      3:       ref_rgb = 24'hFFFFFF;
      default: ref_rgb = 24'hFF00FF;
    endcase
  endfunction

  task automatic set_px(input int s, input int k, input int x, input int y, input int c);
    px_x[s][k] = 10'(x);
    px_y[s][k] = 9'(y);
    px_c[s][k] = 4'(c);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    st_q.delete();
    done_q.delete();
  endtask

  task automatic tick(output int base);
    @(negedge clock);
    frame_tick = 1'b1;
    base = cyc;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int waited = 0;
    while (done_q.size() < n && waited < budget) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (done_q.size() < n) begin
      errors++;
      $display("FAIL %s frame_done: saw %0d pulses in %0d cycles, expected %0d", tag, done_q.size(), budget, n);
    end
  endtask

  // Frame model: slot s launches at L, streams from L+2 for n+1 cycles (MAXC if hung);
  // pixel k appears on fb at L+3+k when on screen; frame_done follows the last slot.
  task automatic check_frame(input int base, input string tag, output int done_c);
    int s_cyc, stream_len, n_w, p, dc;
    st_t st;
    wr_t wr;
    logic [N-1:0] est;
    logic [23:0]  ergb;
    s_cyc = base + 1;
    for (int s = 0; s < N; s++) begin
      est = N'(1) << s;
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL %s start%0d: no pulse seen, expected %b at cycle %0d", tag, s, est, s_cyc);
      end else begin
        st = st_q.pop_front();
        if (st.cyc != s_cyc || st.start !== est) begin
          errors++;
          $display("FAIL %s start%0d: got %b at cycle %0d, expected %b at cycle %0d", tag, s, st.start, st.cyc, est, s_cyc);
        end
      end
      n_w        = hang[s] ? MAXC : n_pix[s];
      stream_len = hang[s] ? MAXC : n_pix[s] + 1;
      for (int k = 0; k < n_w; k++) begin
        p = hang[s] ? 0 : k;
        if (px_x[s][p] < 640 && px_y[s][p] < 480) begin
          ergb = ref_rgb(int'(px_c[s][p]));
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL %s write s%0d k%0d: no write seen, expected (%0d,%0d,%h) at cycle %0d", tag, s, k, px_x[s][p], px_y[s][p], ergb, s_cyc + 3 + k);
          end else begin
            wr = wr_q.pop_front();
            if (wr.cyc != s_cyc + 3 + k || wr.x !== px_x[s][p] || wr.y !== px_y[s][p] || wr.rgb !== ergb) begin
              errors++;
              $display("FAIL %s write s%0d k%0d: got (%0d,%0d,%h) at cycle %0d, expected (%0d,%0d,%h) at cycle %0d", tag, s, k, wr.x, wr.y, wr.rgb, wr.cyc, px_x[s][p], px_y[s][p], ergb, s_cyc + 3 + k);
            end
          end
        end
      end
      s_cyc += 2 + stream_len;
    end
    done_c = s_cyc;
    checks++;
    if (done_q.size() == 0) begin
      errors++;
      $display("FAIL %s frame_done: no pulse, expected at cycle %0d", tag, done_c);
    end else begin
      dc = done_q.pop_front();
      if (dc != done_c) begin
        errors++;
        $display("FAIL %s frame_done: got cycle %0d, expected cycle %0d", tag, dc, done_c);
      end
    end
  endtask

  task automatic check_empty(input string tag);
    checks++;
    if (wr_q.size() != 0 || st_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftovers: got %0d writes %0d starts %0d dones, expected none", tag, wr_q.size(), st_q.size(), done_q.size());
    end
    clear_mon();
  endtask

  task automatic fill_random(input int max_n);
    for (int s = 0; s < N; s++) begin
      hang[s]  = 1'b0;
      n_pix[s] = $urandom_range(0, max_n);
      for (int k = 0; k < n_pix[s]; k++) begin
        set_px(s, k,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 639),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511)  : $urandom_range(0, 479),
               $urandom_range(0, 15));
      end
    end
  endtask

  task automatic test_reset();
    frame_tick = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({drw_init, drw_start, fb_x, fb_y, fb_rgb, fb_we, busy, frame_done, overrun, timeout} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got init=%b start=%b we=%b busy=%b done=%b ovr=%b to=%b fb=(%0d,%0d,%h), expected all 0",
               drw_init, drw_start, fb_we, busy, frame_done, overrun, timeout, fb_x, fb_y, fb_rgb);
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (init_cycles != 1) begin
      errors++;
      $display("FAIL init pulse: got %0d cycles high, expected 1", init_cycles);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle busy: got %b, expected 0", busy);
    end
    check_empty("init");
  endtask

  task automatic test_basic();
    int base, dc;
    for (int s = 0; s < N; s++) begin
      hang[s]  = 1'b0;
      n_pix[s] = 4;
      for (int k = 0; k < 4; k++) set_px(s, k, 100 * s + 10 * k, 50 + 20 * s + k, s + 1);
    end
    clear_mon();
    tick(base);
    wait_frames(1, 200, "basic");
    checks++;
    if (wr_q.size() != 12) begin
      errors++;
      $display("FAIL basic write count: got %0d, expected 12", wr_q.size());
    end
    check_frame(base, "basic", dc);
    check_empty("basic");
  endtask

  task automatic test_clip();
    int base, dc;
    hang[0] = 1'b0; hang[1] = 1'b0; hang[2] = 1'b0;
    n_pix[0] = 1; set_px(0, 0, 0, 0, 1);
    n_pix[1] = 6;
    set_px(1, 0, 700, 10, 1);
    set_px(1, 1, 639, 479, 2);
    set_px(1, 2, 640, 0, 3);
    set_px(1, 3, 0, 480, 1);
    set_px(1, 4, 1023, 511, 0);
    set_px(1, 5, 100, 200, 7);
    n_pix[2] = 2; set_px(2, 0, 320, 240, 3); set_px(2, 1, 639, 0, 15);
    clear_mon();
    tick(base);
    wait_frames(1, 200, "clip");
    checks++;
    if (wr_q.size() != 5) begin
      errors++;
      $display("FAIL clip write count: got %0d, expected 5", wr_q.size());
    end
    check_frame(base, "clip", dc);
    check_empty("clip");
  endtask

  task automatic test_random();
    int base, dc;
    for (int f = 0; f < 10; f++) begin
      fill_random(12);
      clear_mon();
      tick(base);
      wait_frames(1, 400, "random");
      check_frame(base, "random", dc);
      check_empty("random");
    end
  endtask

  task automatic test_tick_on_done();
    int b1, b2, d1, d2;
    bit found = 1'b0;
    fill_random(6);
    clear_mon();
    tick(b1);
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      if (frame_done) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tick_on_done: frame_done not seen within 400 cycles, expected one");
    end
    b2 = cyc;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    wait_frames(2, 400, "tick_on_done");
    check_frame(b1, "tod1", d1);
    check_frame(b2, "tod2", d2);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL tick_on_done overrun: got %b, expected 0", overrun);
    end
    check_empty("tick_on_done");
  endtask

  task automatic test_overrun();
    int base, d1, d2;
    fill_random(5);
    n_pix[0] = 10;
    for (int k = 0; k < 10; k++) set_px(0, k, 30 + k, 40 + k, 1);
    clear_mon();
    tick(base);
    repeat (3) @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    wait_frames(2, 400, "overrun");
    check_frame(base, "ovr1", d1);
    check_frame(d1, "ovr2", d2);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun flag: got %b, expected 1", overrun);
    end
    repeat (40) @(negedge clock);
    check_empty("overrun");
  endtask

  task automatic test_zero_stale();
    int base, dc;
    hang[0] = 1'b0; hang[1] = 1'b0; hang[2] = 1'b0;
    n_pix[0] = 3;
    for (int k = 0; k < 3; k++) set_px(0, k, 7 + k, 9, 3);
    n_pix[1] = 0;
    n_pix[2] = 2; set_px(2, 0, 11, 12, 2); set_px(2, 1, 13, 14, 0);
    clear_mon();
    tick(base);
    wait_frames(1, 200, "zero");
    check_frame(base, "zero", dc);
    check_empty("zero");
  endtask

  task automatic test_timeout();
    int base, dc;
    hang[0] = 1'b0; hang[1] = 1'b0;
    n_pix[0] = 2; set_px(0, 0, 1, 2, 1); set_px(0, 1, 3, 4, 2);
    n_pix[1] = 1; set_px(1, 0, 5, 6, 3);
    n_pix[2] = 0; hang[2] = 1'b1; set_px(2, 0, 10, 20, 3);
    clear_mon();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout before hang: got %b, expected 0", timeout);
    end
    tick(base);
    wait_frames(1, 6000, "timeout");
    check_frame(base, "timeout", dc);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout flag: got %b, expected 1", timeout);
    end
    hang[2] = 1'b0;
    repeat (5) @(negedge clock);
    check_empty("timeout");
  endtask

  task automatic test_reset_abort();
    int base;
    hang[0] = 1'b0; hang[1] = 1'b0; hang[2] = 1'b0;
    n_pix[0] = 20;
    for (int k = 0; k < 20; k++) set_px(0, k, 200 + k, 100, 2);
    n_pix[1] = 0; n_pix[2] = 0;
    clear_mon();
    tick(base);
    for (int i = 0; i < 50 && !fb_we; i++) @(negedge clock);
    checks++;
    if (fb_we !== 1'b1) begin
      errors++;
      $display("FAIL abort setup: fb_we got %b, expected 1 before reset", fb_we);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({fb_we, busy, drw_start, overrun, timeout, frame_done} !== '0) begin
      errors++;
      $display("FAIL abort outputs: got we=%b busy=%b start=%b ovr=%b to=%b done=%b, expected all 0",
               fb_we, busy, drw_start, overrun, timeout, frame_done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_random();
    test_tick_on_done();
    test_overrun();
    test_zero_stale();
    test_timeout();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
